// File: rtl/aes_kat_pkg.sv
// Shared definitions for the AES known-answer-test sequencer.
// Holds the mode encoding, the FSM state type, the FIPS-197 test vectors,
// the per-test vector record and a helper that assembles one record.
package aes_kat_pkg;

    localparam int unsigned NUM_TESTS = 6;
    localparam int unsigned IDX_W     = 3;
    localparam int unsigned MODE_W    = 2;
    localparam int unsigned KEY_W     = 256;
    localparam int unsigned BLOCK_W   = 128;
    localparam int unsigned CNT_W     = 16;

    // Key-size encoding presented to the AES core
    localparam logic [MODE_W-1:0] MODE_128 = 2'd0;
    localparam logic [MODE_W-1:0] MODE_192 = 2'd1;
    localparam logic [MODE_W-1:0] MODE_256 = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_WAIT  = 3'd2,
        ST_NEXT  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // FIPS-197 appendix C vectors; keys are left-aligned in a 256-bit field
    localparam logic [BLOCK_W-1:0] KAT_PT =
        128'h00112233445566778899aabbccddeeff;

    localparam logic [KEY_W-1:0] KAT_KEY128 =
        256'h000102030405060708090a0b0c0d0e0f_00000000000000000000000000000000;
    localparam logic [KEY_W-1:0] KAT_KEY192 =
        256'h000102030405060708090a0b0c0d0e0f1011121314151617_0000000000000000;
    localparam logic [KEY_W-1:0] KAT_KEY256 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    localparam logic [BLOCK_W-1:0] KAT_CT128 =
        128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [BLOCK_W-1:0] KAT_CT192 =
        128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [BLOCK_W-1:0] KAT_CT256 =
        128'h8ea2b7ca516745bfeafc49904b496089;

    // Everything the sequencer needs to run and grade one test
    typedef struct packed {
        logic [MODE_W-1:0]  mode;
        logic               decrypt;
        logic [KEY_W-1:0]   key;
        logic [BLOCK_W-1:0] din;
        logic [BLOCK_W-1:0] expected;
    } kat_vec_t;

    // Builds a test record: encrypt feeds plaintext, decrypt feeds ciphertext
    function automatic kat_vec_t make_vec(
        input logic [MODE_W-1:0]  mode,
        input logic               decrypt,
        input logic [KEY_W-1:0]   key,
        input logic [BLOCK_W-1:0] ct
    );
        kat_vec_t v;
        v.mode     = mode;
        v.decrypt  = decrypt;
        v.key      = key;
        v.din      = decrypt ? ct : KAT_PT;
        v.expected = decrypt ? KAT_PT : ct;
        return v;
    endfunction

endpackage

// File: rtl/aes_kat_rom.sv
// Combinational vector table for the known-answer tests.
// Ports:
//   idx   - test index (0=E128 1=D128 2=E192 3=D192 4=E256 5=D256)
//   vec_c - mode, direction, key, input block and expected output for idx;
//           all zero for indices beyond the last test
module aes_kat_rom
    import aes_kat_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    output kat_vec_t         vec_c
);

    // Index-to-vector lookup
    always_comb begin
        vec_c = '0;
        case (idx)
            3'd0:    vec_c = make_vec(MODE_128, 1'b0, KAT_KEY128, KAT_CT128);
            3'd1:    vec_c = make_vec(MODE_128, 1'b1, KAT_KEY128, KAT_CT128);
            3'd2:    vec_c = make_vec(MODE_192, 1'b0, KAT_KEY192, KAT_CT192);
            3'd3:    vec_c = make_vec(MODE_192, 1'b1, KAT_KEY192, KAT_CT192);
            3'd4:    vec_c = make_vec(MODE_256, 1'b0, KAT_KEY256, KAT_CT256);
            3'd5:    vec_c = make_vec(MODE_256, 1'b1, KAT_KEY256, KAT_CT256);
            default: vec_c = '0;
        endcase
    end

endmodule

// File: rtl/aes_kat_sequencer.sv
// AES power-on self-test sequencer.
// Runs the six FIPS-197 known-answer tests in order against a shared
// iterative AES core and latches one pass LED per test.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   enable               - high runs the tests; low aborts and clears results
//   core_start           - one-cycle request pulse to the core
//   core_mode            - key size (0=128, 1=192, 2=256)
//   core_decrypt         - 1 selects decrypt
//   core_key, core_din   - left-aligned key and input block, stable START..WAIT
//   core_dout, core_done - result block and its one-cycle completion pulse
//   e128..d256           - per-test pass LEDs
//   busy                 - high while a test is in flight (START/WAIT/NEXT)
//   all_done             - high once all six tests have completed
// Parameter:
//   TIMEOUT - cycles to wait for core_done per test (1..65535)
module aes_kat_sequencer
    import aes_kat_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    output logic               core_start,
    output logic [MODE_W-1:0]  core_mode,
    output logic               core_decrypt,
    output logic [KEY_W-1:0]   core_key,
    output logic [BLOCK_W-1:0] core_din,
    input  logic [BLOCK_W-1:0] core_dout,
    input  logic               core_done,
    output logic               e128,
    output logic               d128,
    output logic               e192,
    output logic               d192,
    output logic               e256,
    output logic               d256,
    output logic               busy,
    output logic               all_done
);

    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_TESTS - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    state_t                 state;
    logic [IDX_W-1:0]       idx;
    logic [CNT_W-1:0]       wait_cnt;
    logic [NUM_TESTS-1:0]   pass;

    logic [IDX_W-1:0]       rom_idx_c;
    kat_vec_t               vec_c;
    logic [CNT_W-1:0]       wait_inc_c;
    logic                   timeout_hit_c;
    logic                   match_c;

    // In NEXT the ROM looks one test ahead so START can present the new
    // vector; everywhere else it serves the current test (idx is 0 in IDLE).
    assign rom_idx_c = (state == ST_NEXT) ? IDX_W'(idx + IDX_W'(1)) : idx;

    aes_kat_rom u_rom (
        .idx   (rom_idx_c),
        .vec_c (vec_c)
    );

    // Saturating wait counter increment and timeout detect
    assign wait_inc_c    = (wait_cnt == {CNT_W{1'b1}}) ? wait_cnt
                                                       : CNT_W'(wait_cnt + CNT_W'(1));
    assign timeout_hit_c = (wait_inc_c == TIMEOUT_CNT);

    // Full-width compare; no partial credit
    assign match_c = (core_dout == vec_c.expected);

    // Sequencer FSM, index, wait counter, pass register and core request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            idx          <= '0;
            wait_cnt     <= '0;
            pass         <= '0;
            busy         <= 1'b0;
            all_done     <= 1'b0;
            core_start   <= 1'b0;
            core_mode    <= '0;
            core_decrypt <= 1'b0;
            core_key     <= '0;
            core_din     <= '0;
        end else if (!enable) begin
            // Abort from any state; core request fields keep their last value
            state      <= ST_IDLE;
            idx        <= '0;
            wait_cnt   <= '0;
            pass       <= '0;
            busy       <= 1'b0;
            all_done   <= 1'b0;
            core_start <= 1'b0;
        end else begin
            core_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    state        <= ST_START;
                    busy         <= 1'b1;
                    core_start   <= 1'b1;
                    core_mode    <= vec_c.mode;
                    core_decrypt <= vec_c.decrypt;
                    core_key     <= vec_c.key;
                    core_din     <= vec_c.din;
                end
                ST_START: begin
                    state    <= ST_WAIT;
                    wait_cnt <= '0;
                end
                ST_WAIT: begin
                    // A done coinciding with the timeout still counts
                    if (core_done) begin
                        pass[idx] <= match_c;
                        state     <= ST_NEXT;
                    end else if (timeout_hit_c) begin
                        pass[idx] <= 1'b0;
                        state     <= ST_NEXT;
                    end else begin
                        wait_cnt <= wait_inc_c;
                    end
                end
                ST_NEXT: begin
                    if (idx == LAST_IDX) begin
                        state    <= ST_DONE;
                        busy     <= 1'b0;
                        all_done <= 1'b1;
                    end else begin
                        idx          <= IDX_W'(idx + IDX_W'(1));
                        state        <= ST_START;
                        core_start   <= 1'b1;
                        core_mode    <= vec_c.mode;
                        core_decrypt <= vec_c.decrypt;
                        core_key     <= vec_c.key;
                        core_din     <= vec_c.din;
                    end
                end
                ST_DONE: begin
                    state <= ST_DONE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign e128 = pass[0];
    assign d128 = pass[1];
    assign e192 = pass[2];
    assign d192 = pass[3];
    assign e256 = pass[4];
    assign d256 = pass[5];

endmodule

// File: tb/tb_aes_kat_sequencer.sv
// Self-checking bench for aes_kat_sequencer: a behavioural AES core that
// answers only the FIPS-197 vectors, plus a timeline model deriving expected
// LED/busy/all_done/core_start values from per-test latency and pass mask.
module tb_aes_kat_sequencer;

    localparam int unsigned TO = 20;

    localparam logic [127:0] TB_PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] TB_KEY [3] = '{
        256'h000102030405060708090a0b0c0d0e0f_00000000000000000000000000000000,
        256'h000102030405060708090a0b0c0d0e0f1011121314151617_0000000000000000,
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f
    };
    localparam logic [127:0] TB_CT [3] = '{
        128'h69c4e0d86a7b0430d8cdb78070b4c55a,
        128'hdda97ca4864cdfe06eaf70a0ec0d7191,
        128'h8ea2b7ca516745bfeafc49904b496089
    };

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable;
    logic         core_start;
    logic [1:0]   core_mode;
    logic         core_decrypt;
    logic [255:0] core_key;
    logic [127:0] core_din;
    logic [127:0] core_dout;
    logic         core_done;
    logic         e128, d128, e192, d192, e256, d256;
    logic         busy;
    logic         all_done;

    int errors = 0;
    int checks = 0;

    // Core model controls
    int           lat = 12;
    bit           respond = 1'b1;
    int           corrupt_idx = -1;
    logic         spurious = 1'b0;
    logic [127:0] spurious_dout = '0;

    logic         m_done;
    logic [127:0] m_dout;
    logic [127:0] m_result;
    int           m_cnt;
    bit           m_busy;

    always #5 clk = ~clk;

    aes_kat_sequencer #(.TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .core_start   (core_start),
        .core_mode    (core_mode),
        .core_decrypt (core_decrypt),
        .core_key     (core_key),
        .core_din     (core_din),
        .core_dout    (core_dout),
        .core_done    (core_done),
        .e128         (e128),
        .d128         (d128),
        .e192         (e192),
        .d192         (d192),
        .e256         (e256),
        .d256         (d256),
        .busy         (busy),
        .all_done     (all_done)
    );

    assign core_done = m_done | spurious;
    assign core_dout = spurious ? spurious_dout : m_dout;

    // Behavioural AES: knows only the six KAT transforms, garbage otherwise
    function automatic logic [127:0] core_result(input logic [1:0] mode, input logic dec,
                                                 input logic [255:0] key, input logic [127:0] din);
        logic [127:0] r;
        int t;
        r = ~din;
        t = -1;
        for (int j = 0; j < 3; j++) begin
            if (mode == 2'(j) && key == TB_KEY[j]) begin
                if (!dec && din == TB_PT) begin r = TB_CT[j]; t = 2 * j; end
                if (dec && din == TB_CT[j]) begin r = TB_PT; t = 2 * j + 1; end
            end
        end
        if (t >= 0 && t == corrupt_idx) r[0] = ~r[0];
        return r;
    endfunction

    // Core latency model: done arrives lat edges after the start is sampled
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_done   <= 1'b0;
            m_busy   <= 1'b0;
            m_cnt    <= 0;
            m_dout   <= '0;
            m_result <= '0;
        end else begin
            m_done <= 1'b0;
            if (core_start && respond) begin
                m_busy   <= 1'b1;
                m_cnt    <= lat;
                m_result <= core_result(core_mode, core_decrypt, core_key, core_din);
            end else if (m_busy) begin
                if (m_cnt <= 1) begin
                    m_done <= 1'b1;
                    m_dout <= m_result;
                    m_busy <= 1'b0;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end
    end

    function automatic logic [5:0] leds();
        return {d256, e256, d192, e192, d128, e128};
    endfunction

    // Raise enable and follow the run for ncycles edges. w = WAIT cycles per
    // test, mask = which tests should pass.
    task automatic run_sequence(input string name, input int w, input logic [5:0] mask,
                                input int ncycles);
        int p;
        int k;
        logic [5:0]   exp_leds;
        logic [8:0]   exp_st;
        logic [8:0]   obs_st;
        logic         exp_start;
        logic [127:0] exp_din;
        p = w + 2;
        enable = 1'b1;
        for (int c = 1; c <= ncycles; c++) begin
            @(posedge clk);
            #1;
            for (int t = 0; t < 6; t++) exp_leds[t] = mask[t] && (c >= p * (t + 1));
            exp_start = (c <= 6 * p) && ((c - 1) % p == 0);
            exp_st = {exp_leds, (c <= 6 * p), (c >= 6 * p + 1), exp_start};
            obs_st = {leds(), busy, all_done, core_start};
            checks++;
            if (obs_st !== exp_st) begin
                errors++;
                $display("FAIL %s status c=%0d got leds/busy/done/start=%b required=%b",
                         name, c, obs_st, exp_st);
            end
            if (exp_start) begin
                k = (c - 1) / p;
                exp_din = (k % 2 == 1) ? TB_CT[k / 2] : TB_PT;
                checks++;
                if ({core_mode, core_decrypt, core_key, core_din} !==
                    {2'(k / 2), 1'(k % 2), TB_KEY[k / 2], exp_din}) begin
                    errors++;
                    $display("FAIL %s request test=%0d got mode=%0d dec=%b key=%h din=%h required mode=%0d dec=%0d key=%h din=%h",
                             name, k, core_mode, core_decrypt, core_key, core_din,
                             k / 2, k % 2, TB_KEY[k / 2], exp_din);
                end
            end
        end
    endtask

    // Drop enable and let any in-flight core job drain
    task automatic go_idle(input string name);
        enable = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        checks++;
        if ({leds(), busy, all_done, core_start} !== 9'b0) begin
            errors++;
            $display("FAIL %s idle got leds/busy/done/start=%b required=0",
                     name, {leds(), busy, all_done, core_start});
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({leds(), busy, all_done, core_start} !== 9'b0) begin
            errors++;
            $display("FAIL reset_status got=%b required=0", {leds(), busy, all_done, core_start});
        end
        checks++;
        if ({core_mode, core_decrypt, core_key, core_din} !== '0) begin
            errors++;
            $display("FAIL reset_request got mode=%0d dec=%b key=%h din=%h required all 0",
                     core_mode, core_decrypt, core_key, core_din);
        end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_all_pass();
        lat = 12; respond = 1'b1; corrupt_idx = -1;
        run_sequence("all_pass", 13, 6'h3f, 6 * 15 + 1);
    endtask

    task automatic test_spurious_done();
        spurious_dout = ~TB_PT;
        spurious = 1'b1;
        @(posedge clk);
        #1;
        spurious = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({leds(), busy, all_done, core_start} !== {6'h3f, 3'b010}) begin
                errors++;
                $display("FAIL spurious_done cycle=%0d got=%b required=%b",
                         i, {leds(), busy, all_done, core_start}, {6'h3f, 3'b010});
            end
            @(posedge clk);
            #1;
        end
        go_idle("spurious_done");
    endtask

    task automatic test_corrupt_d192();
        lat = 12; corrupt_idx = 3;
        run_sequence("corrupt_d192", 13, 6'b110111, 6 * 15 + 1);
        go_idle("corrupt_d192");
        corrupt_idx = -1;
    endtask

    task automatic test_timeout();
        respond = 1'b0;
        run_sequence("timeout", TO, 6'h00, 6 * (TO + 2) + 1);
        go_idle("timeout");
        respond = 1'b1;
    endtask

    task automatic test_timeout_boundary();
        lat = TO - 1;
        run_sequence("done_at_timeout", TO, 6'h3f, 6 * (TO + 2) + 1);
        go_idle("done_at_timeout");
        lat = TO;
        run_sequence("done_after_timeout", TO, 6'h00, 6 * (TO + 2) + 1);
        go_idle("done_after_timeout");
    endtask

    task automatic test_abort();
        lat = 12;
        run_sequence("abort_pre", 13, 6'h3f, 64);
        enable = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({leds(), busy, all_done, core_start} !== 9'b0) begin
            errors++;
            $display("FAIL abort_clear got leds/busy/done/start=%b required=0",
                     {leds(), busy, all_done, core_start});
        end
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (core_start !== 1'b0) begin
                errors++;
                $display("FAIL abort_no_start cycle=%0d got=%b required=0", i, core_start);
            end
        end
        run_sequence("abort_rerun", 13, 6'h3f, 6 * 15 + 1);
        go_idle("abort_rerun");
    endtask

    task automatic test_reset_mid_wait();
        lat = 12;
        run_sequence("reset_pre", 13, 6'h3f, 40);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({leds(), busy, all_done, core_start, core_mode, core_decrypt} !== 12'b0 ||
            core_key !== '0 || core_din !== '0) begin
            errors++;
            $display("FAIL reset_mid_wait got status=%b mode=%0d dec=%b key=%h din=%h required all 0",
                     {leds(), busy, all_done, core_start}, core_mode, core_decrypt, core_key, core_din);
        end
        #2;
        rst_n = 1'b1;
        run_sequence("reset_restart", 13, 6'h3f, 6 * 15 + 1);
        go_idle("reset_restart");
    endtask

    task automatic test_random();
        int c;
        int w;
        logic [5:0] mask;
        for (int it = 0; it < 4; it++) begin
            lat = int'($urandom_range(1, TO + 2));
            c = int'($urandom_range(0, 6));
            corrupt_idx = (c == 6) ? -1 : c;
            if (lat + 1 <= int'(TO)) begin
                w = lat + 1;
                mask = 6'h3f;
                if (corrupt_idx >= 0) mask[corrupt_idx] = 1'b0;
            end else begin
                w = TO;
                mask = 6'h00;
            end
            run_sequence($sformatf("random%0d_lat%0d", it, lat), w, mask, 6 * (w + 2) + 1);
            go_idle("random");
        end
        corrupt_idx = -1;
    endtask

    initial begin
        rst_n  = 1'b0;
        enable = 1'b0;
        test_reset();
        test_all_pass();
        test_spurious_done();
        test_corrupt_d192();
        test_timeout();
        test_timeout_boundary();
        test_abort();
        test_reset_mid_wait();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
